up_down_target_ctrl: RTL and testbench

//   Sequencer for the up/down count datapath: accepts a target value, decides direction,

---
 rtl/up_down_target_ctrl_if.sv | 15 +
 rtl/up_down_target_ctrl.sv | 88 ++++++++
 tb/tb_up_down_target_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/up_down_target_ctrl_if.sv
// Command/status bundle between a command source and the up/down target sequencer.
interface up_down_target_ctrl_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] target;
    logic             abort;
    logic [WIDTH-1:0] Q;
    logic             mode;
    logic             busy;
    logic             done;

    modport master (output start, target, abort, input Q, mode, busy, done);
    modport slave  (input start, target, abort, output Q, mode, busy, done);
endinterface

// File: rtl/up_down_target_ctrl.sv
// Sequencer that steps the count register Q one LSB per STEP_DIV cycles toward a captured
// target, reporting direction, busy and a one-cycle done pulse.
module up_down_target_ctrl #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned STEP_DIV = 1
) (
    input logic                  CLK,
    input logic                  Reset,
    up_down_target_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRunUp, StRunDown, StDone} state_e;

    localparam logic [7:0] PreMax = 8'(STEP_DIV - 1);

    state_e           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] tgt_q;
    logic [7:0]       pre_q;
    logic             mode_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] q_step;

    always_comb begin
        q_step = (state_q == StRunDown) ? q_q - WIDTH'(1) : q_q + WIDTH'(1);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= StIdle;
            q_q     <= '0;
            tgt_q   <= '0;
            pre_q   <= '0;
            mode_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        tgt_q <= bus.target;
                        pre_q <= '0;
                        if (bus.target > q_q) begin
                            state_q <= StRunUp;
                            mode_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end else if (bus.target < q_q) begin
                            state_q <= StRunDown;
                            mode_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRunUp, StRunDown: begin
                    // abort wins over a step falling due in the same cycle
                    if (bus.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        pre_q   <= '0;
                    end else if (pre_q == PreMax) begin
                        pre_q <= '0;
                        q_q   <= q_step;
                        if (q_step == tgt_q) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        pre_q <= pre_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.Q    = q_q;
    assign bus.mode = mode_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_up_down_target_ctrl.sv
// Directed bench for up_down_target_ctrl: STEP_DIV=1 main instance plus a STEP_DIV=3 instance.
module tb_up_down_target_ctrl;
    logic CLK = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    always #5 CLK = ~CLK;

    up_down_target_ctrl_if #(.WIDTH(4)) bus1 ();
    up_down_target_ctrl_if #(.WIDTH(4)) bus3 ();

    up_down_target_ctrl #(.WIDTH(4), .STEP_DIV(1)) dut1 (.CLK(CLK), .Reset(Reset), .bus(bus1));
    up_down_target_ctrl #(.WIDTH(4), .STEP_DIV(3)) dut3 (.CLK(CLK), .Reset(Reset), .bus(bus3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (bus1.done === 1'b1) n_done++;
    endtask

    task automatic check_st(input string tag, input int q, input int mode, input int busy,
                            input int done);
        check({tag, ".Q"}, 32'(bus1.Q), 32'(q));
        check({tag, ".mode"}, 32'(bus1.mode), 32'(mode));
        check({tag, ".busy"}, 32'(bus1.busy), 32'(busy));
        check({tag, ".done"}, 32'(bus1.done), 32'(done));
    endtask

    // Start a run on dut1 and check state after the accepting edge.
    task automatic start_run(input logic [3:0] tgt, input string tag, input int q, input int mode,
                             input int busy, input int done);
        bus1.start  = 1'b1;
        bus1.target = tgt;
        tick();
        bus1.start = 1'b0;
        check_st(tag, q, mode, busy, done);
    endtask

    initial begin
        bus1.start = 1'b0; bus1.target = '0; bus1.abort = 1'b0;
        bus3.start = 1'b0; bus3.target = '0; bus3.abort = 1'b0;
        Reset = 1'b1;
        tick();
        tick();
        check_st("reset", 0, 1, 0, 0);
        check("reset3.Q", 32'(bus3.Q), 0);
        Reset = 1'b0;

        // 1: 0 -> 5 up
        start_run(4'd5, "t1.accept", 0, 1, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_st($sformatf("t1.step%0d", i), i, 1, (i < 5) ? 1 : 0, (i == 5) ? 1 : 0);
        end
        tick();
        check_st("t1.idle", 5, 1, 0, 0);

        // 2: 5 -> 2 down
        start_run(4'd2, "t2.accept", 5, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_st($sformatf("t2.step%0d", i), 5 - i, 0, (i < 3) ? 1 : 0, (i == 3) ? 1 : 0);
        end
        tick();
        check_st("t2.idle", 2, 0, 0, 0);

        // 3: equal target -> immediate done, mode unchanged
        start_run(4'd2, "t3.accept", 2, 0, 0, 1);
        tick();
        check_st("t3.idle", 2, 0, 0, 0);

        // 4: 2 -> 12 aborted at Q=6, with a stray start mid-run
        n_done = 0;
        start_run(4'd12, "t4.accept", 2, 1, 1, 0);
        tick();
        check_st("t4.q3", 3, 1, 1, 0);
        bus1.start = 1'b1; bus1.target = 4'd0;
        tick();
        bus1.start = 1'b0;
        check_st("t4.q4_stray_start", 4, 1, 1, 0);
        tick();
        tick();
        check_st("t4.q6", 6, 1, 1, 0);
        bus1.abort = 1'b1;
        tick();
        bus1.abort = 1'b0;
        check_st("t4.abort", 6, 1, 0, 0);
        tick();
        check_st("t4.idle", 6, 1, 0, 0);
        check("t4.no_done", 32'(n_done), 0);

        // 5: back to 0, then full range 0 -> 15 -> 0
        start_run(4'd0, "t5.down0", 6, 0, 1, 0);
        for (int i = 0; i < 6; i++) tick();
        check_st("t5.at0", 0, 0, 0, 1);
        tick();
        n_done = 0;
        start_run(4'd15, "t5.up_accept", 0, 1, 1, 0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check($sformatf("t5.up.Q%0d", i), 32'(bus1.Q), 32'(i));
        end
        check("t5.up.done", 32'(bus1.done), 1);
        tick();
        start_run(4'd0, "t5.dn_accept", 15, 0, 1, 0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check($sformatf("t5.dn.Q%0d", i), 32'(bus1.Q), 32'(15 - i));
        end
        check("t5.dn.done", 32'(bus1.done), 1);
        tick();
        check("t5.done_count", 32'(n_done), 2);
        check_st("t5.idle", 0, 0, 0, 0);

        // STEP_DIV=3: 0 -> 2, Q changes every third edge
        bus3.start = 1'b1; bus3.target = 4'd2;
        tick();
        bus3.start = 1'b0;
        check("t5d3.busy", 32'(bus3.busy), 1);
        for (int j = 1; j <= 6; j++) begin
            tick();
            check($sformatf("t5d3.Q%0d", j), 32'(bus3.Q), 32'(j / 3));
            check($sformatf("t5d3.done%0d", j), 32'(bus3.done), (j == 6) ? 1 : 0);
        end

        // 6: reset during run at Q=9, start held with reset ignored
        start_run(4'd15, "t6.accept", 0, 1, 1, 0);
        for (int i = 0; i < 9; i++) tick();
        check_st("t6.q9", 9, 1, 1, 0);
        Reset = 1'b1; bus1.start = 1'b1; bus1.target = 4'd3;
        tick();
        check_st("t6.reset", 0, 1, 0, 0);
        tick();
        check_st("t6.reset_start", 0, 1, 0, 0);
        Reset = 1'b0; bus1.start = 1'b0;
        tick();
        check_st("t6.after", 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
